ycr_sleep_ctrl: RTL and testbench
=================================

Name: ycr_sleep_ctrl

Overview:
Upstream companion of the core clock gate. It accepts a sleep request from the RISC-V CSR path and waits for the bus to drain. It then drives the gate's dst_idle input. It also double-syncs raw interrupts and latches them sticky before presenting them as irq1/irq2/irq3, so short pulses cannot be missed. It runs on the free-running (ungated) clock and tracks the gate's wakeup pulse to return the core to run.

Parameters:
DRAIN_TMO, 64, max cycles spent in DRAIN waiting for bus_idle before the request is aborted
CNT_W, 7, width of the drain/wake counter; must satisfy 2^CNT_W > DRAIN_TMO
WAKE_HOLD, 4, cycles spent in WAKE after the wakeup pulse; matches the gate's post-wake timer

Ports:
clk_in  input  1  free-running clock (never gated)
reset_n  input  1  reset, asynchronous, active-low
sleep_req  input  1  one-cycle pulse from CSR: request sleep
bus_idle  input  1  core/bus quiescent; synchronous to clk_in
irq_raw  input  3  asynchronous interrupt sources
irq_clr  input  3  W1C pulse that clears the sticky pending bits
wakeup  input  1  one-cycle pulse from the clock gate
dst_idle  output  1  to gate dst_idle; registered
irq_out  output  3  sticky pending bits to gate irq1/irq2/irq3
wake_cause  output  3  snapshot of irq_out taken at wakeup
sleep_nack  output  1  one-cycle pulse: request rejected or aborted
sleep_done  output  1  one-cycle pulse: sleep cycle completed, back in RUN
sleep_active  output  1  high in any state other than RUN

Behaviour:
- Reset: state=RUN, all outputs 0, counter 0, sync/pend flops 0.
- IRQ path, per bit:
  - ff1 <= irq_raw, ff2 <= ff1, ff2_r <= ff2; rise = ff2 & ~ff2_r.
  - pend <= rise ? 1 : (irq_clr ? 0 : pend). Set wins over a simultaneous clear.
  - irq_out = pend. raw high before edge N gives irq_out high after edge N+2.
- FSM, states RUN/DRAIN/SLEEP/WAKE (2-bit encoding):
  - RUN: dst_idle=0.
    - sleep_req with |irq_out=1: sleep_nack pulses next cycle, stay RUN.
    - sleep_req otherwise: go to DRAIN, counter <= DRAIN_TMO-1.
    - sleep_req is ignored in every state except RUN.
  - DRAIN: the following are checked in priority order:
    1. |irq_out: abort to RUN, sleep_nack pulse.
    2. bus_idle: go to SLEEP, dst_idle <= 1.
    3. counter==0: abort to RUN, sleep_nack pulse.
    4. Otherwise counter decrements.
    - Total DRAIN residency is at most DRAIN_TMO cycles.
  - SLEEP: dst_idle=1.
    - On wakeup: go to WAKE, dst_idle <= 0, wake_cause <= irq_out, counter <= WAKE_HOLD-1.
    - With no wakeup the block stays here indefinitely; the gate's mode decides which irq wakes it.
  - WAKE: counter decrements. At 0: go to RUN, sleep_done pulse.
    - Another wakeup arriving in WAKE is ignored.
- A wakeup pulse in RUN or DRAIN is ignored.
- wake_cause holds its value until the next wakeup capture. Reset clears it.
- dst_idle is a plain register, so there are no glitches on the gate's sync input.
- Asynchronous reset mid-sleep returns immediately to RUN with dst_idle=0. Pending bits are lost.

Decomposition:
- Package ycr_sleep_pkg:
  - state enum (RUN=2'b00, DRAIN=2'b01, SLEEP=2'b10, WAKE=2'b11)
  - IRQ_W=3
- Sub-module ycr_irq_pend (one instance, IRQ_W wide): wraps the existing ctech_dsync_high cell plus the edge/sticky logic.
- FSM and counter stay in the top module.

Test Plan:
1. sleep_req with bus_idle=1, irq idle -> DRAIN for 1 cycle, then dst_idle=1 and sleep_active=1; irq_raw[1] pulsed for 1 cycle -> irq_out=3'b010 two edges later; wakeup pulse -> dst_idle=0, wake_cause=3'b010, sleep_done exactly 4 cycles later.
2. sleep_req with bus_idle=0 held -> sleep_nack exactly 64 cycles after entering DRAIN, state RUN, dst_idle never 1.
3. irq_out=3'b001 pending when sleep_req arrives -> sleep_nack the next cycle, no DRAIN entry; irq_clr=3'b001 -> irq_out=0.
4. irq_raw[2] rise coincides with an irq_clr[2] pulse on the pend update edge -> irq_out[2]=1 (set wins); an irq rising during DRAIN -> abort with sleep_nack.
5. reset_n asserted asynchronously while in SLEEP -> dst_idle, irq_out and wake_cause go to 0 without a clock edge; a second wakeup in WAKE does not extend WAKE_HOLD.

Source files
------------

// File: rtl/ycr_sleep_pkg.sv
// Shared types for the sleep controller: FSM state encoding and IRQ width.
package ycr_sleep_pkg;

  localparam int unsigned IRQ_W = 3;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    SLEEP = 2'b10,
    WAKE  = 2'b11
  } state_e;

endpackage

// File: rtl/ycr_irq_pend.sv
// Interrupt capture: double-sync of raw sources, rising-edge detect and
// sticky pending bits with write-1-to-clear. A set wins over a clear.

module ctech_dsync_high #(
  parameter int unsigned WB = 1
) (
  input  logic [WB-1:0] in_data,
  input  logic          out_clk,
  input  logic          out_rst_n,
  output logic [WB-1:0] out_data
);

  logic [WB-1:0] r_meta;

  always_ff @(posedge out_clk or negedge out_rst_n) begin
    if (!out_rst_n) begin
      r_meta   <= '0;
      out_data <= '0;
    end else begin
      r_meta   <= in_data;
      out_data <= r_meta;
    end
  end

endmodule

module ycr_irq_pend
  import ycr_sleep_pkg::*;
#(
  parameter int unsigned W = IRQ_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_irq_raw,
  input  logic [W-1:0] i_irq_clr,
  output logic [W-1:0] o_irq_pend
);

  logic [W-1:0] w_sync;
  logic [W-1:0] w_rise;
  logic [W-1:0] r_sync_d;
  logic [W-1:0] r_pend;

  ctech_dsync_high #(.WB(W)) u_dsync (
    .in_data   (i_irq_raw),
    .out_clk   (i_clk),
    .out_rst_n (i_rst_n),
    .out_data  (w_sync)
  );

  assign w_rise = w_sync & ~r_sync_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_d <= '0;
      r_pend   <= '0;
    end else begin
      r_sync_d <= w_sync;
      r_pend   <= w_rise | (r_pend & ~i_irq_clr);
    end
  end

  assign o_irq_pend = r_pend;

endmodule

// File: rtl/ycr_sleep_ctrl.sv
// Sleep sequencer in front of the core clock gate: drains the bus, drives
// dst_idle, tracks the gate's wakeup pulse and presents sticky interrupts.
module ycr_sleep_ctrl
  import ycr_sleep_pkg::*;
#(
  parameter int unsigned DRAIN_TMO = 64,
  parameter int unsigned CNT_W     = 7,
  parameter int unsigned WAKE_HOLD = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             sleep_req,
  input  logic             bus_idle,
  input  logic [IRQ_W-1:0] irq_raw,
  input  logic [IRQ_W-1:0] irq_clr,
  input  logic             wakeup,
  output logic             dst_idle,
  output logic [IRQ_W-1:0] irq_out,
  output logic [IRQ_W-1:0] wake_cause,
  output logic             sleep_nack,
  output logic             sleep_done,
  output logic             sleep_active
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IRQ_W-1:0]   w_irq_pend;
  logic               w_irq_any;

  ycr_irq_pend #(.W(IRQ_W)) u_irq_pend (
    .i_clk      (clk_in),
    .i_rst_n    (reset_n),
    .i_irq_raw  (irq_raw),
    .i_irq_clr  (irq_clr),
    .o_irq_pend (w_irq_pend)
  );

  assign irq_out      = w_irq_pend;
  assign w_irq_any    = |w_irq_pend;
  assign sleep_active = (r_state != RUN);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= RUN;
      r_cnt      <= '0;
      dst_idle   <= 1'b0;
      wake_cause <= '0;
      sleep_nack <= 1'b0;
      sleep_done <= 1'b0;
    end else begin
      sleep_nack <= 1'b0;
      sleep_done <= 1'b0;
      case (r_state)
        RUN: begin
          dst_idle <= 1'b0;
          if (sleep_req) begin
            if (w_irq_any) begin
              sleep_nack <= 1'b1;
            end else begin
              r_state <= DRAIN;
              r_cnt   <= CNT_W'(DRAIN_TMO - 1);
            end
          end
        end
        // Pending irq outranks bus_idle so a request never sleeps over one.
        DRAIN: begin
          if (w_irq_any) begin
            r_state    <= RUN;
            sleep_nack <= 1'b1;
          end else if (bus_idle) begin
            r_state  <= SLEEP;
            dst_idle <= 1'b1;
          end else if (r_cnt == '0) begin
            r_state    <= RUN;
            sleep_nack <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        SLEEP: begin
          if (wakeup) begin
            r_state    <= WAKE;
            dst_idle   <= 1'b0;
            wake_cause <= w_irq_pend;
            r_cnt      <= CNT_W'(WAKE_HOLD - 1);
          end
        end
        WAKE: begin
          if (r_cnt == '0) begin
            r_state    <= RUN;
            sleep_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_ycr_sleep_ctrl.sv
// Directed self-checking bench for ycr_sleep_ctrl.
module tb_ycr_sleep_ctrl;

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       sleep_req;
  logic       bus_idle;
  logic [2:0] irq_raw;
  logic [2:0] irq_clr;
  logic       wakeup;
  logic       dst_idle;
  logic [2:0] irq_out;
  logic [2:0] wake_cause;
  logic       sleep_nack;
  logic       sleep_done;
  logic       sleep_active;

  int checks = 0;
  int errors = 0;

  ycr_sleep_ctrl #(.DRAIN_TMO(64), .CNT_W(7), .WAKE_HOLD(4)) dut (
    .clk_in       (clk_in),
    .reset_n      (reset_n),
    .sleep_req    (sleep_req),
    .bus_idle     (bus_idle),
    .irq_raw      (irq_raw),
    .irq_clr      (irq_clr),
    .wakeup       (wakeup),
    .dst_idle     (dst_idle),
    .irq_out      (irq_out),
    .wake_cause   (wake_cause),
    .sleep_nack   (sleep_nack),
    .sleep_done   (sleep_done),
    .sleep_active (sleep_active)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; sleep_req = 1'b0; bus_idle = 1'b0;
    irq_raw = '0; irq_clr = '0; wakeup = 1'b0;
    #3;
    checks++; if (dst_idle !== 1'b0) begin errors++; $display("FAIL reset_dst_idle got %0b exp 0", dst_idle); end
    checks++; if (irq_out !== 3'b000) begin errors++; $display("FAIL reset_irq_out got %b exp 000", irq_out); end
    checks++; if (wake_cause !== 3'b000) begin errors++; $display("FAIL reset_wake_cause got %b exp 000", wake_cause); end
    checks++; if (sleep_nack !== 1'b0) begin errors++; $display("FAIL reset_nack got %0b exp 0", sleep_nack); end
    checks++; if (sleep_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", sleep_done); end
    checks++; if (sleep_active !== 1'b0) begin errors++; $display("FAIL reset_active got %0b exp 0", sleep_active); end
    #9 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_sleep_wake();
    bus_idle = 1'b1;
    sleep_req = 1'b1; tick(); sleep_req = 1'b0;
    checks++; if (sleep_active !== 1'b1 || dst_idle !== 1'b0) begin errors++; $display("FAIL drain_entry active=%0b dst_idle=%0b exp 1/0", sleep_active, dst_idle); end
    tick();
    checks++; if (dst_idle !== 1'b1 || sleep_active !== 1'b1) begin errors++; $display("FAIL sleep_entry dst_idle=%0b active=%0b exp 1/1", dst_idle, sleep_active); end
    irq_raw = 3'b010; tick(); irq_raw = '0;
    checks++; if (irq_out !== 3'b000) begin errors++; $display("FAIL irq_lat_n got %b exp 000", irq_out); end
    tick();
    checks++; if (irq_out !== 3'b000) begin errors++; $display("FAIL irq_lat_n1 got %b exp 000", irq_out); end
    tick();
    checks++; if (irq_out !== 3'b010) begin errors++; $display("FAIL irq_lat_n2 got %b exp 010", irq_out); end
    wakeup = 1'b1; tick(); wakeup = 1'b0;
    checks++; if (dst_idle !== 1'b0 || wake_cause !== 3'b010) begin errors++; $display("FAIL wake_capture dst_idle=%0b cause=%b exp 0/010", dst_idle, wake_cause); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (sleep_done !== 1'b0 || sleep_active !== 1'b1) begin errors++; $display("FAIL wake_hold_%0d done=%0b active=%0b exp 0/1", i, sleep_done, sleep_active); end
    end
    tick();
    checks++; if (sleep_done !== 1'b1 || sleep_active !== 1'b0) begin errors++; $display("FAIL sleep_done done=%0b active=%0b exp 1/0", sleep_done, sleep_active); end
    tick();
    checks++; if (sleep_done !== 1'b0) begin errors++; $display("FAIL done_pulse got %0b exp 0", sleep_done); end
    irq_clr = 3'b010; tick(); irq_clr = '0;
    checks++; if (irq_out !== 3'b000 || wake_cause !== 3'b010) begin errors++; $display("FAIL clr_keeps_cause irq=%b cause=%b exp 000/010", irq_out, wake_cause); end
  endtask

  task automatic test_drain_timeout();
    int bad = 0;
    bus_idle = 1'b0;
    sleep_req = 1'b1; tick(); sleep_req = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      tick();
      if (sleep_nack !== 1'b0 || dst_idle !== 1'b0 || sleep_active !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL drain_wait bad_cycles got %0d exp 0", bad); end
    tick();
    checks++; if (sleep_nack !== 1'b1 || sleep_active !== 1'b0 || dst_idle !== 1'b0) begin errors++; $display("FAIL drain_tmo nack=%0b active=%0b dst_idle=%0b exp 1/0/0", sleep_nack, sleep_active, dst_idle); end
    tick();
    checks++; if (sleep_nack !== 1'b0) begin errors++; $display("FAIL tmo_nack_pulse got %0b exp 0", sleep_nack); end
  endtask

  task automatic test_irq_reject();
    irq_raw = 3'b001; tick(); irq_raw = '0;
    tick(); tick();
    checks++; if (irq_out !== 3'b001) begin errors++; $display("FAIL rej_pend got %b exp 001", irq_out); end
    bus_idle = 1'b1;
    sleep_req = 1'b1; tick(); sleep_req = 1'b0;
    checks++; if (sleep_nack !== 1'b1 || sleep_active !== 1'b0) begin errors++; $display("FAIL rej_nack nack=%0b active=%0b exp 1/0", sleep_nack, sleep_active); end
    tick();
    checks++; if (sleep_nack !== 1'b0 || sleep_active !== 1'b0) begin errors++; $display("FAIL rej_after nack=%0b active=%0b exp 0/0", sleep_nack, sleep_active); end
    irq_clr = 3'b001; tick(); irq_clr = '0;
    checks++; if (irq_out !== 3'b000) begin errors++; $display("FAIL rej_clr got %b exp 000", irq_out); end
  endtask

  task automatic test_set_wins();
    irq_raw = 3'b100; tick(); irq_raw = '0;
    tick();
    irq_clr = 3'b100; tick(); irq_clr = '0;
    checks++; if (irq_out !== 3'b100) begin errors++; $display("FAIL set_wins got %b exp 100", irq_out); end
    irq_clr = 3'b100; tick(); irq_clr = '0;
    checks++; if (irq_out !== 3'b000) begin errors++; $display("FAIL set_wins_clr got %b exp 000", irq_out); end
    bus_idle = 1'b0;
    sleep_req = 1'b1; tick(); sleep_req = 1'b0;
    irq_raw = 3'b001; tick(); irq_raw = '0;
    tick(); tick();
    checks++; if (sleep_active !== 1'b1 || sleep_nack !== 1'b0 || irq_out !== 3'b001) begin errors++; $display("FAIL drain_irq_pre active=%0b nack=%0b irq=%b exp 1/0/001", sleep_active, sleep_nack, irq_out); end
    tick();
    checks++; if (sleep_nack !== 1'b1 || sleep_active !== 1'b0) begin errors++; $display("FAIL drain_irq_abort nack=%0b active=%0b exp 1/0", sleep_nack, sleep_active); end
    irq_clr = 3'b001; tick(); irq_clr = '0;
    checks++; if (irq_out !== 3'b000) begin errors++; $display("FAIL drain_irq_clr got %b exp 000", irq_out); end
  endtask

  task automatic test_back_to_back();
    wakeup = 1'b1; tick(); wakeup = 1'b0;
    checks++; if (sleep_active !== 1'b0 || wake_cause !== 3'b010) begin errors++; $display("FAIL run_wakeup active=%0b cause=%b exp 0/010", sleep_active, wake_cause); end
    bus_idle = 1'b1;
    sleep_req = 1'b1; tick(); sleep_req = 1'b0;
    tick();
    wakeup = 1'b1; tick(); wakeup = 1'b0;
    checks++; if (wake_cause !== 3'b000 || dst_idle !== 1'b0) begin errors++; $display("FAIL b2b_cause cause=%b dst_idle=%0b exp 000/0", wake_cause, dst_idle); end
    tick();
    wakeup = 1'b1; tick(); wakeup = 1'b0;
    tick();
    checks++; if (sleep_done !== 1'b0 || sleep_active !== 1'b1) begin errors++; $display("FAIL b2b_hold done=%0b active=%0b exp 0/1", sleep_done, sleep_active); end
    tick();
    checks++; if (sleep_done !== 1'b1 || sleep_active !== 1'b0) begin errors++; $display("FAIL b2b_no_extend done=%0b active=%0b exp 1/0", sleep_done, sleep_active); end
  endtask

  task automatic test_async_reset();
    bus_idle = 1'b1;
    sleep_req = 1'b1; tick(); sleep_req = 1'b0;
    tick();
    irq_raw = 3'b100; tick(); irq_raw = '0;
    tick(); tick();
    wakeup = 1'b1; tick(); wakeup = 1'b0;
    repeat (4) tick();
    irq_clr = 3'b100; tick(); irq_clr = '0;
    sleep_req = 1'b1; tick(); sleep_req = 1'b0;
    tick();
    irq_raw = 3'b010; tick(); irq_raw = '0;
    tick(); tick();
    checks++; if (dst_idle !== 1'b1 || wake_cause !== 3'b100 || irq_out !== 3'b010) begin errors++; $display("FAIL arst_pre dst_idle=%0b cause=%b irq=%b exp 1/100/010", dst_idle, wake_cause, irq_out); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (dst_idle !== 1'b0 || irq_out !== 3'b000 || wake_cause !== 3'b000 || sleep_active !== 1'b0) begin errors++; $display("FAIL arst_async dst_idle=%0b irq=%b cause=%b active=%0b exp 0/000/000/0", dst_idle, irq_out, wake_cause, sleep_active); end
    #10 reset_n = 1'b1;
    tick();
    checks++; if (sleep_active !== 1'b0 || dst_idle !== 1'b0) begin errors++; $display("FAIL arst_post active=%0b dst_idle=%0b exp 0/0", sleep_active, dst_idle); end
  endtask

  initial begin
    test_reset();
    test_sleep_wake();
    test_drain_timeout();
    test_irq_reject();
    test_set_wins();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
